// File: rtl/nand_sweep_controller.sv
// Sweeps all 16 input vectors across a 4-input NAND under test, settling before each sample,
// and reports the mismatch count and the first failing vector.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start, stimulus 0000
// ST_SETTLE | vector applied, counting settle cycles
// ST_CHECK  | single cycle; y sampled at the edge that ends it
// ST_DONE   | sweep complete, results and stimulus 1111 held
module nand_sweep_controller #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic [3:0] first_fail
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [3:0] vec, vec_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [4:0] err_nxt;
   logic [3:0] ff_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         vec        <= 4'd0;
         cnt        <= 4'd0;
         err_cnt    <= 5'd0;
         first_fail <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         state      <= state_nxt;
         vec        <= vec_nxt;
         cnt        <= cnt_nxt;
         err_cnt    <= err_nxt;
         first_fail <= ff_nxt;
         busy       <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
         done       <= (state_nxt == ST_DONE);
         pass       <= (state_nxt == ST_DONE) && (err_nxt == 5'd0);
      end
   end

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      err_nxt   = err_cnt;
      ff_nxt    = first_fail;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_SETTLE;
               vec_nxt   = 4'd0;
               cnt_nxt   = 4'd0;
               err_nxt   = 5'd0;
               ff_nxt    = 4'd0;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               vec_nxt   = 4'd0;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
               if (cnt == LAST_CNT) state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               vec_nxt   = 4'd0;
               cnt_nxt   = 4'd0;
            end else begin
               // ideal NAND answers 1 everywhere except the all-ones vector
               if (y != (vec != 4'hF)) begin
                  err_nxt = err_cnt + 5'd1;
                  if (err_cnt == 5'd0) ff_nxt = vec;
               end
               if (vec == 4'hF) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_SETTLE;
                  vec_nxt   = vec + 4'd1;
                  cnt_nxt   = 4'd0;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign {a, b, c, d} = vec;

endmodule

// File: doc/nand_sweep_controller.md
NAND_SWEEP_CONTROLLER -- requirements
Module: nand_sweep_controller

Interface
REQ-001 Parameter: SETTLE, default 2, number of settle cycles per vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin a sweep; sampled only in IDLE or DONE.
REQ-005 abort  input  1  terminate a sweep in progress; sampled only in SETTLE or CHECK.
REQ-006 y  input  1  response of the 4-input NAND gate under test.
REQ-007 a, b, c, d  output  1 each  gate stimulus; {a,b,c,d} = current vector, a is the MSB.
REQ-008 busy  output  1  high in SETTLE and CHECK.
REQ-009 done  output  1  high in DONE.
REQ-010 pass  output  1  high in DONE when err_cnt == 0; low in all other states.
REQ-011 err_cnt  output  5  number of mismatching vectors in the current or last sweep, 0..16.
REQ-012 first_fail  output  4  first mismatching vector; valid only when err_cnt != 0.

Function
REQ-013 FSM states: IDLE, SETTLE, CHECK, DONE; all outputs registered; no combinational path from any input to any output.
REQ-014 IDLE: {a,b,c,d} = 4'b0000, busy = 0, done = 0; start = 1 -> SETTLE with vec = 0, settle counter = 0, err_cnt = 0, first_fail = 0.
REQ-015 SETTLE: settle counter +1 per cycle; on the edge where counter == SETTLE-1 -> CHECK; vec held.
REQ-016 CHECK lasts exactly one cycle; y is sampled at the edge that ends CHECK.
REQ-017 Expected response = ~(a & b & c & d): 1 for vectors 0..14, 0 for vector 15.
REQ-018 Mismatch at the CHECK edge: err_cnt +1; if err_cnt was 0, first_fail <= vec. err_cnt needs no saturation (max 16).
REQ-019 From CHECK with vec != 15: vec <= vec + 1, counter <= 0 -> SETTLE; with vec == 15: -> DONE, vec held at 15, no wrap.
REQ-020 Cost per vector is SETTLE + 1 cycles; a full sweep is 16*(SETTLE+1) cycles from the start edge to the edge that enters DONE (48 cycles at SETTLE = 2).
REQ-021 DONE: done = 1, pass = (err_cnt == 0), err_cnt and first_fail held, {a,b,c,d} held at 4'b1111; start = 1 -> restart exactly as from IDLE (REQ-014).
REQ-022 start while busy = 1 is ignored; the sweep continues unaffected.
REQ-023 abort = 1 in SETTLE or CHECK -> IDLE on the next edge; no comparison is made on that edge; err_cnt and first_fail keep their current values; {a,b,c,d} return to 0000.
REQ-024 Simultaneous abort and CHECK-final-vector edge: abort wins; -> IDLE, done never asserts.
REQ-025 abort in IDLE or DONE has no effect.

Reset
REQ-026 rst = 1 forces immediately, without waiting for a clock edge: state IDLE, vec = 0, counter = 0, {a,b,c,d} = 0000, busy = 0, done = 0, pass = 0, err_cnt = 0, first_fail = 0.
REQ-027 Reset mid-sweep discards all progress; after release, the block waits in IDLE for start.

Verification
REQ-028 Ideal NAND model on y, SETTLE = 2, pulse start -> vectors 0..15 each held 3 cycles; done at cycle 48; pass = 1, err_cnt = 0.
REQ-029 y stuck at 1 -> err_cnt = 1, first_fail = 4'hF, pass = 0.
REQ-030 y stuck at 0 -> err_cnt = 15, first_fail = 4'h0, pass = 0.
REQ-031 Assert rst asynchronously at vector 7 -> outputs reach reset values before the next clock edge; start after release gives a clean full sweep (err_cnt = 0 with the ideal model).
REQ-032 abort at vector 5 -> IDLE on the next edge, a..d = 0000, done = 0; a start pulse during the busy phase of a following sweep is ignored, and that sweep completes normally.
REQ-033 Start in DONE after a failing sweep, now with the ideal model -> err_cnt cleared to 0 and first_fail cleared at the restart edge; ends with pass = 1.
